// File: rtl/gate_tester_pkg.sv
// Shared encodings for the gate tester: gate-under-test op codes and FSM states.
package gate_tester_pkg;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_NAND = 2'b11;

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_DRIVE  = 2'b01;
    localparam logic [1:0] ST_SAMPLE = 2'b10;
    localparam logic [1:0] ST_DONE   = 2'b11;

    localparam int unsigned NUM_VEC = 4;

endpackage

// File: rtl/gate_tester_ref.sv
// Golden model of the gate under test: expected output for the latched op.
module gate_ref
    import gate_tester_pkg::*;
(
    input  logic [1:0] op,
    input  logic       a,
    input  logic       b,
    output logic       y_exp
);

    always_comb begin
        y_exp = 1'b0;
        case (op)
            OP_AND:  y_exp = a & b;
            OP_OR:   y_exp = a | b;
            OP_XOR:  y_exp = a ^ b;
            OP_NAND: y_exp = ~(a & b);
            default: y_exp = 1'b0;
        endcase
    end

endmodule

// File: rtl/gate_tester.sv
// Walks a 2-input gate through all four input vectors, lets each settle for
// SETTLE_CYCLES, samples y and accumulates a per-vector mismatch report.
module gate_tester
    import gate_tester_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] op,
    output logic       a,
    output logic       b,
    input  logic       y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_cnt,
    output logic [3:0] fail_mask
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    logic [1:0] state_q, state_d;
    logic [1:0] op_q, op_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [2:0] err_q, err_d;
    logic [3:0] mask_q, mask_d;

    logic       y_exp;
    logic       mism;
    logic [2:0] err_nxt;

    gate_ref u_ref (
        .op    (op_q),
        .a     (idx_q[1]),
        .b     (idx_q[0]),
        .y_exp (y_exp)
    );

    assign mism    = (y != y_exp);
    // Saturate at four so a stray extra sample can never wrap the count.
    assign err_nxt = (mism && err_q != 3'd4) ? err_q + 3'd1 : err_q;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        err_d   = err_q;
        mask_d  = mask_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_DRIVE;
                    op_d    = op;
                    idx_d   = 2'd0;
                    cnt_d   = 4'd0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    err_d   = 3'd0;
                    mask_d  = 4'd0;
                end
            end
            ST_DRIVE: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == SETTLE_LAST) state_d = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                err_d = err_nxt;
                if (mism) mask_d[idx_q] = 1'b1;
                // Index 3 drives a=b=1, which is left on the pins in DONE.
                if (idx_q == 2'd3) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_nxt == 3'd0);
                end else begin
                    state_d = ST_DRIVE;
                    idx_d   = idx_q + 2'd1;
                    cnt_d   = 4'd0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_AND;
            idx_q   <= 2'd0;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= 3'd0;
            mask_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            mask_q  <= mask_d;
        end
    end

    assign a         = idx_q[1];
    assign b         = idx_q[0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_cnt   = err_q;
    assign fail_mask = mask_q;

endmodule
